// File: rtl/uart_bridge_pkg.sv
// Shared constants and types for the UART-to-bus command bridge.
// Optional build macro: UART_BRIDGE_CHECKSUM_EN (adds a trailing XOR checksum byte).
package uart_bridge_pkg;

    // Frame header bytes selecting the operation
    localparam logic [7:0] HDR_WR = 8'h5A;
    localparam logic [7:0] HDR_RD = 8'hA5;

    // Default response bytes
    localparam logic [7:0] ACK_DEFAULT = 8'h06;
    localparam logic [7:0] NAK_DEFAULT = 8'h15;

    // Bridge FSM state encoding; GET_SUM is only reachable in checksum builds
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GET_ADDR  = 3'd1,
        GET_DATA  = 3'd2,
        GET_SUM   = 3'd3,
        BUS_REQ   = 3'd4,
        BUS_WAIT  = 3'd5,
        SEND      = 3'd6,
        SEND_WAIT = 3'd7
    } state_t;

    // True for a byte that may start a frame
    function automatic logic is_header(input logic [7:0] b);
        return (b == HDR_WR) || (b == HDR_RD);
    endfunction

endpackage

// File: rtl/uart_bridge_timer.sv
// Loadable / clearable down-counter with an expiry indication.
// expired is high while enabled, not being reloaded, and the count has reached zero;
// the owner leaves the enabling state on that cycle, so it behaves as a pulse.
module uart_bridge_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load has priority over clear, then decrement saturating at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && !load && (cnt_q == '0);

endmodule

// File: rtl/uart_bus_bridge.sv
// UART command-frame to single-master bus bridge.
// Frames: 5A,addr,data (write) or A5,addr (read); one response byte per frame
// (ACK on write, read data on read, NAK on bus timeout).
// Optional build macro: UART_BRIDGE_CHECKSUM_EN -- frames carry a trailing byte equal to
// the XOR of the preceding frame bytes; a mismatch skips the bus access and returns NAK.
// Handshakes: receive_finish is a one-cycle strobe qualifying receive_data; the bus request
// level (bus_write/bus_read) is held with stable addr/wdata until the first cycle bus_ready=1,
// then drops the following cycle; send_start is a one-cycle strobe issued only while
// send_busy=0, and send_data is held until send_finish.
import uart_bridge_pkg::*;

module uart_bus_bridge #(
    parameter int         IDLE_TO  = 1000000,
    parameter int         BUS_TO   = 255,
    parameter logic [7:0] ACK_BYTE = ACK_DEFAULT,
    parameter logic [7:0] NAK_BYTE = NAK_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       receive_finish,
    input  logic [7:0] receive_data,
    output logic       send_start,
    input  logic       send_busy,
    input  logic       send_finish,
    output logic [7:0] send_data,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    output logic       bus_write,
    output logic       bus_read,
    input  logic       bus_ready,
    input  logic [7:0] bus_rdata,
    output logic [2:0] dbg_state
);

    localparam int              IDLE_W    = $clog2(IDLE_TO + 1);
    localparam int              BUS_W     = $clog2(BUS_TO + 1);
    localparam logic [IDLE_W-1:0] IDLE_LOAD = IDLE_W'(IDLE_TO - 1);
    localparam logic [BUS_W-1:0]  BUS_LOAD  = BUS_W'(BUS_TO - 1);

    state_t     state_q, state_d;
    logic       is_wr_q, is_wr_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       write_q, write_d;
    logic       read_q, read_d;
    logic       start_q, start_d;
    logic [7:0] send_data_q, send_data_d;
`ifdef UART_BRIDGE_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;
`endif

    logic idle_en, idle_load, idle_clr, idle_exp;
    logic bus_en, bus_load, bus_clr, bus_exp;

    // Inter-byte timer runs only while collecting frame bytes; reloads on every accepted byte
    always_comb begin
        idle_en   = (state_q == GET_ADDR) || (state_q == GET_DATA) || (state_q == GET_SUM);
        idle_load = receive_finish &&
                    (idle_en || ((state_q == IDLE) && is_header(receive_data)));
        idle_clr  = !idle_en && !idle_load;
    end

    // Bus timer is armed on the edge that raises the request and runs while it is held
    always_comb begin
        bus_en   = (state_q == BUS_REQ) || (state_q == BUS_WAIT);
        bus_load = (state_d == BUS_REQ) && (state_q != BUS_REQ);
        bus_clr  = !bus_en && !bus_load;
    end

    uart_bridge_timer #(.W(IDLE_W)) u_idle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (idle_load),
        .clear    (idle_clr),
        .enable   (idle_en),
        .load_val (IDLE_LOAD),
        .expired  (idle_exp)
    );

    uart_bridge_timer #(.W(BUS_W)) u_bus_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (bus_load),
        .clear    (bus_clr),
        .enable   (bus_en),
        .load_val (BUS_LOAD),
        .expired  (bus_exp)
    );

    // Frame parsing, bus request and response sequencing; a received byte beats a timeout
    always_comb begin
        state_d     = state_q;
        is_wr_d     = is_wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        write_d     = write_q;
        read_d      = read_q;
        start_d     = 1'b0;
        send_data_d = send_data_q;
`ifdef UART_BRIDGE_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        case (state_q)
            IDLE: begin
                if (receive_finish && is_header(receive_data)) begin
                    is_wr_d = (receive_data == HDR_WR);
                    state_d = GET_ADDR;
`ifdef UART_BRIDGE_CHECKSUM_EN
                    sum_d   = receive_data;
`endif
                end
            end
            GET_ADDR: begin
                if (receive_finish) begin
                    addr_d = receive_data;
`ifdef UART_BRIDGE_CHECKSUM_EN
                    sum_d   = sum_q ^ receive_data;
                    state_d = is_wr_q ? GET_DATA : GET_SUM;
`else
                    if (is_wr_q) begin
                        state_d = GET_DATA;
                    end else begin
                        state_d = BUS_REQ;
                        read_d  = 1'b1;
                    end
`endif
                end else if (idle_exp) begin
                    state_d = IDLE;
                end
            end
            GET_DATA: begin
                if (receive_finish) begin
                    wdata_d = receive_data;
`ifdef UART_BRIDGE_CHECKSUM_EN
                    sum_d   = sum_q ^ receive_data;
                    state_d = GET_SUM;
`else
                    state_d = BUS_REQ;
                    write_d = 1'b1;
`endif
                end else if (idle_exp) begin
                    state_d = IDLE;
                end
            end
`ifdef UART_BRIDGE_CHECKSUM_EN
            GET_SUM: begin
                if (receive_finish) begin
                    if (receive_data == sum_q) begin
                        state_d = BUS_REQ;
                        write_d = is_wr_q;
                        read_d  = !is_wr_q;
                    end else begin
                        state_d     = SEND;
                        send_data_d = NAK_BYTE;
                    end
                end else if (idle_exp) begin
                    state_d = IDLE;
                end
            end
`endif
            BUS_REQ, BUS_WAIT: begin
                if (bus_ready) begin
                    write_d     = 1'b0;
                    read_d      = 1'b0;
                    send_data_d = is_wr_q ? ACK_BYTE : bus_rdata;
                    state_d     = SEND;
                end else if (bus_exp) begin
                    write_d     = 1'b0;
                    read_d      = 1'b0;
                    send_data_d = NAK_BYTE;
                    state_d     = SEND;
                end else begin
                    state_d = BUS_WAIT;
                end
            end
            SEND: begin
                if (!send_busy) begin
                    start_d = 1'b1;
                    state_d = SEND_WAIT;
                end
            end
            SEND_WAIT: begin
                if (send_finish) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                write_d = 1'b0;
                read_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            is_wr_q     <= 1'b0;
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
            write_q     <= 1'b0;
            read_q      <= 1'b0;
            start_q     <= 1'b0;
            send_data_q <= 8'h00;
`ifdef UART_BRIDGE_CHECKSUM_EN
            sum_q       <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            is_wr_q     <= is_wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            read_q      <= read_d;
            start_q     <= start_d;
            send_data_q <= send_data_d;
`ifdef UART_BRIDGE_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign send_start = start_q;
    assign send_data  = send_data_q;
    assign bus_addr   = addr_q;
    assign bus_wdata  = wdata_q;
    assign bus_write  = write_q;
    assign bus_read   = read_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Scoreboard bench for uart_bus_bridge: random and directed command frames, a bus slave
// with programmable wait states, and a transmitter model. Expected bus transactions and
// response bytes come from a memory-based reference model of the command protocol.
module tb_uart_bus_bridge;

    localparam int         IDLE_TO = 50;
    localparam int         BUS_TO  = 8;
    localparam logic [7:0] ACK     = 8'h06;
    localparam logic [7:0] NAK     = 8'h15;
    localparam logic [7:0] HWR     = 8'h5A;
    localparam logic [7:0] HRD     = 8'hA5;

    logic       clk;
    logic       rst_n;
    logic       receive_finish;
    logic [7:0] receive_data;
    logic       send_start;
    logic       send_busy;
    logic       send_finish;
    logic [7:0] send_data;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_write;
    logic       bus_read;
    logic       bus_ready;
    logic [7:0] bus_rdata;
    logic [2:0] dbg_state;

    int checks;
    int errors;
    int cyc;
    int last_rf_cyc;
    int resp_total;
    int resp_done;

    logic [17:0] exp_bus_q[$];
    int          exp_len_q[$];
    logic [7:0]  exp_q[$];
    int          exp_lat_q[$];

    logic [7:0] model_mem [256];
    logic [7:0] slave_mem [256];
    int         slave_wait;
    bit         slave_hang;
    logic       tx_busy;
    logic       ext_busy;

    assign send_busy = tx_busy | ext_busy;

    uart_bus_bridge #(.IDLE_TO(IDLE_TO), .BUS_TO(BUS_TO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .receive_finish (receive_finish),
        .receive_data   (receive_data),
        .send_start     (send_start),
        .send_busy      (send_busy),
        .send_finish    (send_finish),
        .send_data      (send_data),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_write      (bus_write),
        .bus_read       (bus_read),
        .bus_ready      (bus_ready),
        .bus_rdata      (bus_rdata),
        .dbg_state      (dbg_state)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Drive one received byte as a one-cycle strobe, then idle for gap cycles
    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        receive_finish = 1'b1;
        receive_data   = b;
        last_rf_cyc    = cyc;
        @(negedge clk);
        receive_finish = 1'b0;
        receive_data   = $urandom_range(0, 255);
        repeat (gap) @(negedge clk);
    endtask

    // Issue one complete frame and record what the bridge must do with it
    task automatic do_frame(input bit wr, input logic [7:0] addr, input logic [7:0] data,
                            input int wt, input bit hang, input int gap, input bit lat_ok,
                            input bit drop_after);
        logic [7:0] fr[$];
        logic [7:0] resp;
        logic [7:0] sum;
        slave_wait = wt;
        slave_hang = hang;
        exp_bus_q.push_back({wr, !wr, addr, wr ? data : 8'h00});
        exp_len_q.push_back(hang ? BUS_TO : wt + 1);
        if (hang) resp = NAK;
        else if (wr) resp = ACK;
        else resp = model_mem[addr];
        if (wr && !hang) model_mem[addr] = data;
        exp_q.push_back(resp);
        resp_total++;
        exp_lat_q.push_back((lat_ok && !drop_after) ? (hang ? BUS_TO + 2 : wt + 3) : -1);
        fr.push_back(wr ? HWR : HRD);
        fr.push_back(addr);
        if (wr) fr.push_back(data);
`ifdef UART_BRIDGE_CHECKSUM_EN
        sum = 8'h00;
        foreach (fr[i]) sum = sum ^ fr[i];
        fr.push_back(sum);
`else
        sum = 8'h00;
`endif
        foreach (fr[i]) send_byte(fr[i], (i == fr.size() - 1) ? 0 : gap);
        if (drop_after) send_byte(HWR, 0);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((resp_done != resp_total) && (n < 800)) begin
            @(negedge clk);
            n++;
        end
        check("response_count", 32'(resp_done), 32'(resp_total));
    endtask

    // Bus slave: answers after slave_wait request cycles unless hanging; random ready when idle
    initial begin : bus_slave
        int k;
        k = 0;
        bus_ready = 1'b0;
        bus_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (bus_write || bus_read) begin
                if (!slave_hang && (k == slave_wait)) begin
                    bus_ready = 1'b1;
                    bus_rdata = slave_mem[bus_addr];
                    if (bus_write) slave_mem[bus_addr] = bus_wdata;
                end else begin
                    bus_ready = 1'b0;
                    bus_rdata = 8'($urandom_range(0, 255));
                end
                k++;
            end else begin
                k = 0;
                bus_ready = ($urandom_range(0, 3) == 0);
                bus_rdata = 8'($urandom_range(0, 255));
            end
        end
    end

    // Bus monitor: checks each request against the expected transaction queue
    initial begin : bus_monitor
        bit         prev;
        bit         req;
        int         len;
        logic [7:0] ha;
        logic [7:0] hw;
        logic       hwr;
        bit         stable;
        logic [17:0] e;
        prev = 0;
        len = 0;
        stable = 1;
        ha = 8'h00;
        hw = 8'h00;
        hwr = 1'b0;
        forever begin
            @(negedge clk);
            req = bus_write || bus_read;
            if (!rst_n) begin
                prev = 0;
            end else begin
                if (req && !prev) begin
                    if (exp_bus_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL bus_unexpected got wr=%0b rd=%0b addr %0h expected none",
                                 bus_write, bus_read, bus_addr);
                    end else begin
                        e = exp_bus_q.pop_front();
                        check("bus_txn", 32'({bus_write, bus_read, bus_addr,
                                              bus_write ? bus_wdata : 8'h00}), 32'(e));
                    end
                    check("req_latency", 32'(cyc - last_rf_cyc), 32'd1);
                    len = 1;
                    ha = bus_addr;
                    hw = bus_wdata;
                    hwr = bus_write;
                    stable = 1;
                end else if (req && prev) begin
                    len++;
                    if ((bus_addr !== ha) || (bus_wdata !== hw) || (bus_write !== hwr)) stable = 0;
                end else if (!req && prev) begin
                    if (exp_len_q.size() > 0) check("req_length", 32'(len), 32'(exp_len_q.pop_front()));
                    check("req_stable", 32'(stable), 32'd1);
                end
                prev = req;
            end
        end
    end

    // Transmitter model and response monitor
    initial begin : send_monitor
        logic [7:0] held;
        int         n;
        int         lat;
        bit         ok;
        tx_busy = 1'b0;
        send_finish = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && send_start) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_unexpected got %0h expected none", send_data);
                end else begin
                    check("resp_byte", 32'(send_data), 32'(exp_q.pop_front()));
                end
                check("start_while_idle_tx", 32'(send_busy), 32'd0);
                lat = (exp_lat_q.size() > 0) ? exp_lat_q.pop_front() : -1;
                if (lat >= 0) check("start_latency", 32'(cyc - last_rf_cyc), 32'(lat));
                held = send_data;
                tx_busy = 1'b1;
                ok = 1;
                n = $urandom_range(1, 5);
                repeat (n) begin
                    @(negedge clk);
                    if (send_start || (send_data !== held)) ok = 0;
                end
                send_finish = 1'b1;
                @(negedge clk);
                if (send_start || (send_data !== held)) ok = 0;
                send_finish = 1'b0;
                tx_busy = 1'b0;
                check("send_hold_pulse", 32'(ok), 32'd1);
                resp_done++;
            end
        end
    end

    // Global time limit
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog got timeout expected completion");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    // Stimulus
    initial begin : stimulus
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] j;
        bit         wr;
        checks = 0;
        errors = 0;
        resp_total = 0;
        resp_done = 0;
        last_rf_cyc = 0;
        slave_wait = 0;
        slave_hang = 0;
        ext_busy = 1'b0;
        receive_finish = 1'b0;
        receive_data = 8'h00;
        for (int i = 0; i < 256; i++) begin
            slave_mem[i] = 8'($urandom_range(0, 255));
            model_mem[i] = slave_mem[i];
        end
        slave_mem[8'h22] = 8'h9E;
        model_mem[8'h22] = 8'h9E;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({send_start, send_data, bus_addr, bus_wdata, bus_write, bus_read}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write with one wait state
        do_frame(1'b1, 8'h10, 8'h3C, 1, 1'b0, 0, 1'b1, 1'b0);
        wait_done();
        // Zero-wait read
        do_frame(1'b0, 8'h22, 8'h00, 0, 1'b0, 0, 1'b1, 1'b0);
        wait_done();
        // Non-header bytes dropped before a frame
        send_byte(8'h00, 0);
        send_byte(8'hFF, 1);
        do_frame(1'b1, 8'h01, 8'h02, 0, 1'b0, 0, 1'b1, 1'b0);
        wait_done();
        // Timeout in GET_DATA: 51-cycle byte spacing discards the partial write
        send_byte(HWR, 0);
        send_byte(8'h10, 49);
        do_frame(1'b0, 8'h07, 8'h00, 0, 1'b0, 0, 1'b1, 1'b0);
        wait_done();
        // Timeout in GET_ADDR
        send_byte(HWR, 49);
        do_frame(1'b0, 8'h33, 8'h00, 2, 1'b0, 0, 1'b1, 1'b0);
        wait_done();
        // Byte arriving exactly at the expiry cycle is still accepted
        do_frame(1'b1, 8'h44, 8'hC3, 0, 1'b0, 48, 1'b1, 1'b0);
        wait_done();
        // Bus timeout with a stray byte during the wait
        do_frame(1'b0, 8'h55, 8'h00, 0, 1'b1, 0, 1'b1, 1'b1);
        wait_done();
        // Ready on the very last allowed request cycle
        do_frame(1'b1, 8'h66, 8'h5B, BUS_TO - 1, 1'b0, 2, 1'b1, 1'b0);
        wait_done();
        // Transmitter busy when the response is ready
        ext_busy = 1'b1;
        do_frame(1'b0, 8'h44, 8'h00, 1, 1'b0, 0, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        ext_busy = 1'b0;
        wait_done();
        // Reset mid-frame aborts without a response
        send_byte(HWR, 0);
        send_byte(8'h10, 0);
        rst_n = 1'b0;
        #1;
        check("reset_midframe", 32'({send_start, bus_addr, bus_wdata, bus_write, bus_read}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_frame(1'b0, 8'h10, 8'h00, 0, 1'b0, 0, 1'b1, 1'b0);
        wait_done();
`ifdef UART_BRIDGE_CHECKSUM_EN
        // Bad checksum: no bus access, NAK
        exp_q.push_back(NAK);
        exp_lat_q.push_back(-1);
        resp_total++;
        send_byte(HWR, 0);
        send_byte(8'h10, 0);
        send_byte(8'h3C, 0);
        send_byte(8'h00, 0);
        wait_done();
`endif
        // Randomized frames
        for (int i = 0; i < 30; i++) begin
            wr = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
            d = 8'($urandom_range(0, 255));
            for (int k = 0; k < $urandom_range(0, 2); k++) begin
                do j = 8'($urandom_range(0, 255)); while ((j == HWR) || (j == HRD));
                send_byte(j, $urandom_range(0, 3));
            end
            do_frame(wr, a, d, $urandom_range(0, 5), ($urandom_range(0, 9) == 0),
                     $urandom_range(0, 12), 1'b1, 1'b0);
            wait_done();
        end

        repeat (5) @(negedge clk);
        check("bus_queue_empty", 32'(exp_bus_q.size()), 32'd0);
        check("resp_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
